// File: rtl/aes_pkg.sv
// Shared AES byte-substitution tables and lookup helpers used by the S-box
// pipeline and the key-expansion datapath.
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [0:255][7:0] FWD_SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic byte_t sbox_fwd(input byte_t b);
        return FWD_SBOX[b];
    endfunction

    function automatic byte_t sbox_inv(input byte_t b);
        return INV_SBOX[b];
    endfunction

endpackage

// File: rtl/sbox_pipe_if.sv
// Input/output valid-ready channels of the S-box pipeline; the master side
// produces input words and consumes results.
interface sbox_pipe_if #(parameter int LANES = 4) ();

    logic               in_valid;
    logic               in_ready;
    logic               in_inv;
    logic [8*LANES-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_inv;
    logic [8*LANES-1:0] out_data;

    modport master (
        output in_valid, in_inv, in_data, out_ready,
        input  in_ready, out_valid, out_inv, out_data
    );

    modport slave (
        input  in_valid, in_inv, in_data, out_ready,
        output in_ready, out_valid, out_inv, out_data
    );

endinterface

// File: rtl/sbox_lane.sv
// Single-byte combinational S-box lookup; inv_i selects the inverse table.
module sbox_lane
    import aes_pkg::*;
(
    input  byte_t byte_i,
    input  logic  inv_i,
    output byte_t byte_o
);

    assign byte_o = inv_i ? sbox_inv(byte_i) : sbox_fwd(byte_i);

endmodule

// File: rtl/sbox_pipe.sv
// Multi-lane AES SubBytes/InvSubBytes pipeline with a global stall enable
// and a wrapping count of completed output transfers.
module sbox_pipe
    import aes_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    sbox_pipe_if.slave       bus,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int W = 8 * LANES;

    logic [STAGES-1:0] stageValid_q;
    logic              stageInv_q  [STAGES];
    logic [W-1:0]      stageData_q [STAGES];
    logic [W-1:0]      subData;
    logic [CNT_W-1:0]  xferCnt_q;
    logic [CNT_W-1:0]  xferCnt_d;
    logic              advanceEn;
    logic              outFire;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox_lane u_lane (
            .byte_i (bus.in_data[8*g +: 8]),
            .inv_i  (bus.in_inv),
            .byte_o (subData[8*g +: 8])
        );
    end

    // Bubbles are not collapsed: the whole pipe moves or holds as one.
    assign advanceEn     = !stageValid_q[STAGES-1] || bus.out_ready;
    assign outFire       = stageValid_q[STAGES-1] && bus.out_ready;
    assign bus.in_ready  = advanceEn;
    assign bus.out_valid = stageValid_q[STAGES-1];
    assign bus.out_inv   = stageInv_q[STAGES-1];
    assign bus.out_data  = stageData_q[STAGES-1];
    assign xfer_cnt      = xferCnt_q;

    always_comb begin
        xferCnt_d = xferCnt_q;
        if (outFire) begin
            xferCnt_d = xferCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stageValid_q <= '0;
            xferCnt_q    <= '0;
        end else begin
            xferCnt_q <= xferCnt_d;
            if (advanceEn) begin
                stageValid_q[0] <= bus.in_valid;
                for (int s = 1; s < STAGES; s++) begin
                    stageValid_q[s] <= stageValid_q[s-1];
                end
            end
        end
    end

    // Payload registers carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (advanceEn) begin
            stageInv_q[0]  <= bus.in_inv;
            stageData_q[0] <= subData;
            for (int s = 1; s < STAGES; s++) begin
                stageInv_q[s]  <= stageInv_q[s-1];
                stageData_q[s] <= stageData_q[s-1];
            end
        end
    end

endmodule

// File: tb/tb_sbox_pipe.sv
// Self-checking bench for sbox_pipe: three parameterisations, S-box model
// derived from GF(2^8) inversion plus the AES affine map.
module tb_sbox_pipe;

    logic        clk;
    logic        rst;
    logic [3:0]  cntA;
    logic [15:0] cntB;
    logic [15:0] cntC;

    int errors = 0;
    int checks = 0;
    int expCntA = 0;
    int expCntB = 0;
    int expCntC = 0;

    logic [7:0]  refFwd [256];
    logic [7:0]  refInv [256];
    logic [31:0] srcData [$];
    logic        srcInv  [$];
    logic [32:0] gotWord [$];

    sbox_pipe_if #(.LANES(4))  busA ();
    sbox_pipe_if #(.LANES(1))  busB ();
    sbox_pipe_if #(.LANES(16)) busC ();

    sbox_pipe #(.LANES(4), .STAGES(2), .CNT_W(4)) dutA (
        .clk(clk), .rst(rst), .bus(busA), .xfer_cnt(cntA));
    sbox_pipe #(.LANES(1), .STAGES(1), .CNT_W(16)) dutB (
        .clk(clk), .rst(rst), .bus(busB), .xfer_cnt(cntB));
    sbox_pipe #(.LANES(16), .STAGES(4), .CNT_W(16)) dutC (
        .clk(clk), .rst(rst), .bus(busC), .xfer_cnt(cntC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] affineSbox(input logic [7:0] x);
        logic [7:0] v;
        v = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(x, 8'(c)) == 8'h01) v = 8'(c);
        end
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] refWord(input logic [127:0] d, input logic inv, input int lanes);
        logic [127:0] r;
        r = '0;
        for (int l = 0; l < lanes; l++) begin
            r[8*l +: 8] = inv ? refInv[d[8*l +: 8]] : refFwd[d[8*l +: 8]];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        busA.in_valid = 0; busA.in_inv = 0; busA.in_data = '0; busA.out_ready = 1;
        busB.in_valid = 0; busB.in_inv = 0; busB.in_data = '0; busB.out_ready = 1;
        busC.in_valid = 0; busC.in_inv = 0; busC.in_data = '0; busC.out_ready = 1;
    endtask

    task automatic runStreamA(input int maxCyc, output int cyc);
        int idx;
        idx = 0; cyc = 0;
        gotWord.delete();
        while (gotWord.size() < srcData.size() && cyc < maxCyc) begin
            if (idx < srcData.size()) begin
                busA.in_valid = 1; busA.in_data = srcData[idx]; busA.in_inv = srcInv[idx];
            end else begin
                busA.in_valid = 0;
            end
            busA.out_ready = 1;
            #1;
            if (busA.out_valid) gotWord.push_back({busA.out_inv, busA.out_data});
            if (busA.in_valid && busA.in_ready) idx++;
            tick();
            cyc++;
        end
        busA.in_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        applyStimulus();
        tick(); tick();
        checks++; if (busA.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_validA: got %b want 0", busA.out_valid); end
        checks++; if (busA.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_readyA: got %b want 1", busA.in_ready); end
        checks++; if (cntA !== 4'd0) begin errors++; $display("[TB] FAIL rst_cntA: got %0d want 0", cntA); end
        checks++; if (busB.out_valid !== 1'b0 || busC.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_validBC: got %b%b want 00", busB.out_valid, busC.out_valid); end
        rst = 0;
        tick();
        checks++; if (busA.out_valid !== 1'b0 || cntA !== 4'd0) begin errors++; $display("[TB] FAIL post_rstA: valid %b cnt %0d want 0 0", busA.out_valid, cntA); end
        checks++; if (busA.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_rst_readyA: got %b want 1", busA.in_ready); end
    endtask

    task automatic knownVectorA(input logic [31:0] din, input logic inv, input logic [31:0] want, input string name);
        logic [127:0] model;
        model = refWord({96'd0, din}, inv, 4);
        busA.in_valid = 1; busA.in_inv = inv; busA.in_data = din; busA.out_ready = 1;
        #1;
        checks++; if (busA.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s_ready: got %b want 1", name, busA.in_ready); end
        tick();
        busA.in_valid = 0;
        #1;
        checks++; if (busA.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s_early: out_valid %b want 0", name, busA.out_valid); end
        tick();
        checks++;
        if (busA.out_valid !== 1'b1 || busA.out_data !== want || busA.out_inv !== inv) begin
            errors++; $display("[TB] FAIL %s_data: got v%b i%b %h want v1 i%b %h", name, busA.out_valid, busA.out_inv, busA.out_data, inv, want);
        end
        checks++; if (want !== model[31:0]) begin errors++; $display("[TB] FAIL %s_model: model %h want %h", name, model[31:0], want); end
        tick();
        expCntA++;
        checks++; if (cntA !== 4'(expCntA) || busA.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s_cnt: cnt %0d valid %b want %0d 0", name, cntA, busA.out_valid, expCntA % 16); end
    endtask

    task automatic test_forward();
        knownVectorA(32'hff530100, 1'b0, 32'h16ed7c63, "fwd_known");
    endtask

    task automatic test_inverse();
        int cyc;
        logic [31:0] fwdWords [64];
        logic [127:0] m;
        logic [31:0] orig;
        knownVectorA(32'h16ed7c63, 1'b1, 32'hff530100, "inv_known");
        srcData.delete(); srcInv.delete();
        for (int k = 0; k < 64; k++) begin
            srcData.push_back({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
            srcInv.push_back(1'b0);
        end
        runStreamA(300, cyc);
        checks++; if (gotWord.size() != 64 || cyc != 66) begin errors++; $display("[TB] FAIL sweep_fwd_count: got %0d words in %0d cycles want 64 in 66", gotWord.size(), cyc); end
        for (int k = 0; k < gotWord.size(); k++) begin
            m = refWord({96'd0, srcData[k]}, 1'b0, 4);
            fwdWords[k] = gotWord[k][31:0];
            checks++; if (gotWord[k] !== {1'b0, m[31:0]}) begin errors++; $display("[TB] FAIL sweep_fwd[%0d]: got %h want %h", k, gotWord[k], {1'b0, m[31:0]}); end
        end
        expCntA += gotWord.size();
        srcData.delete(); srcInv.delete();
        for (int k = 0; k < 64; k++) begin
            srcData.push_back(fwdWords[k]);
            srcInv.push_back(1'b1);
        end
        runStreamA(300, cyc);
        checks++; if (gotWord.size() != 64) begin errors++; $display("[TB] FAIL sweep_inv_count: got %0d want 64", gotWord.size()); end
        for (int k = 0; k < gotWord.size(); k++) begin
            orig = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            checks++; if (gotWord[k] !== {1'b1, orig}) begin errors++; $display("[TB] FAIL roundtrip[%0d]: got %h want %h", k, gotWord[k], {1'b1, orig}); end
        end
        expCntA += gotWord.size();
        checks++; if (cntA !== 4'(expCntA)) begin errors++; $display("[TB] FAIL sweep_cnt: got %0d want %0d", cntA, expCntA % 16); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [6];
        logic        pat [4];
        logic [127:0] m;
        int idx, outIdx, cyc;
        logic prevStall, prevInv, expRdy, sawDup;
        logic [31:0] prevData;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) words[k] = $urandom();
        idx = 0; outIdx = 0; cyc = 0; prevStall = 0; prevInv = 0; prevData = '0;
        while (outIdx < 6 && cyc < 80) begin
            busA.in_valid = (idx < 6);
            busA.in_data  = (idx < 6) ? words[idx] : 32'h0;
            busA.in_inv   = idx[0];
            busA.out_ready = pat[cyc % 4];
            #1;
            if (prevStall) begin
                checks++;
                if (busA.out_valid !== 1'b1 || busA.out_data !== prevData || busA.out_inv !== prevInv) begin
                    errors++; $display("[TB] FAIL bp_stable: got v%b i%b %h want v1 i%b %h", busA.out_valid, busA.out_inv, busA.out_data, prevInv, prevData);
                end
            end
            expRdy = !(busA.out_valid && !busA.out_ready);
            checks++; if (busA.in_ready !== expRdy) begin errors++; $display("[TB] FAIL bp_ready: got %b want %b", busA.in_ready, expRdy); end
            if (busA.out_valid && busA.out_ready) begin
                m = refWord({96'd0, words[outIdx]}, outIdx[0], 4);
                checks++;
                if (busA.out_data !== m[31:0] || busA.out_inv !== outIdx[0]) begin
                    errors++; $display("[TB] FAIL bp_word[%0d]: got i%b %h want i%b %h", outIdx, busA.out_inv, busA.out_data, outIdx[0], m[31:0]);
                end
                outIdx++; expCntA++;
            end
            prevStall = busA.out_valid && !busA.out_ready;
            prevData  = busA.out_data;
            prevInv   = busA.out_inv;
            if (busA.in_valid && busA.in_ready) idx++;
            tick();
            cyc++;
        end
        busA.in_valid = 0; busA.out_ready = 1;
        checks++; if (outIdx != 6) begin errors++; $display("[TB] FAIL bp_timeout: got %0d words want 6", outIdx); end
        sawDup = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (busA.out_valid) sawDup = 1;
            tick();
        end
        checks++; if (sawDup !== 1'b0) begin errors++; $display("[TB] FAIL bp_dup: extra word seen %b want 0", sawDup); end
        checks++; if (cntA !== 4'(expCntA)) begin errors++; $display("[TB] FAIL bp_cnt: got %0d want %0d", cntA, expCntA % 16); end
    endtask

    task automatic test_reset_midstream();
        logic sawStale;
        busA.out_ready = 0;
        busA.in_valid = 1; busA.in_inv = 0; busA.in_data = $urandom();
        tick();
        busA.in_inv = 1; busA.in_data = $urandom();
        tick();
        busA.in_valid = 0;
        #1;
        checks++; if (busA.out_valid !== 1'b1 || busA.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_fill: valid %b ready %b want 1 0", busA.out_valid, busA.in_ready); end
        rst = 1; busA.out_ready = 1; busA.in_valid = 1; busA.in_data = $urandom();
        tick();
        rst = 0; busA.in_valid = 0;
        #1;
        checks++; if (busA.out_valid !== 1'b0 || cntA !== 4'd0) begin errors++; $display("[TB] FAIL mid_rst: valid %b cnt %0d want 0 0", busA.out_valid, cntA); end
        expCntA = 0; expCntB = 0; expCntC = 0;
        sawStale = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (busA.out_valid) sawStale = 1;
            tick();
        end
        checks++; if (sawStale !== 1'b0 || cntA !== 4'd0) begin errors++; $display("[TB] FAIL mid_stale: stale %b cnt %0d want 0 0", sawStale, cntA); end
    endtask

    task automatic test_counter_wrap();
        logic [31:0] words [17];
        logic [127:0] m;
        int idx, outs, cyc;
        logic fire;
        for (int k = 0; k < 17; k++) words[k] = $urandom();
        idx = 0; outs = 0; cyc = 0;
        while (outs < 17 && cyc < 100) begin
            busA.in_valid = (idx < 17);
            busA.in_data  = (idx < 17) ? words[idx] : 32'h0;
            busA.in_inv   = 1'b0;
            busA.out_ready = 1;
            #1;
            fire = busA.out_valid && busA.out_ready;
            if (fire) begin
                m = refWord({96'd0, words[outs]}, 1'b0, 4);
                checks++; if (busA.out_data !== m[31:0]) begin errors++; $display("[TB] FAIL wrap_data[%0d]: got %h want %h", outs, busA.out_data, m[31:0]); end
            end
            if (busA.in_valid && busA.in_ready) idx++;
            tick();
            cyc++;
            if (fire) begin
                outs++; expCntA++;
                checks++; if (cntA !== 4'(expCntA)) begin errors++; $display("[TB] FAIL wrap_cnt[%0d]: got %0d want %0d", outs, cntA, expCntA % 16); end
            end
        end
        busA.in_valid = 0;
        checks++; if (outs != 17 || cntA !== 4'd1) begin errors++; $display("[TB] FAIL wrap_final: outs %0d cnt %0d want 17 1", outs, cntA); end
    endtask

    task automatic test_corner_small();
        logic [7:0] bytes [8];
        logic       invs  [8];
        logic [127:0] m;
        busB.out_ready = 1;
        busB.in_valid = 1; busB.in_inv = 0; busB.in_data = 8'h53;
        tick();
        busB.in_valid = 0;
        #1;
        checks++; if (busB.out_valid !== 1'b1 || busB.out_data !== 8'hed) begin errors++; $display("[TB] FAIL small_known: got v%b %h want v1 ed", busB.out_valid, busB.out_data); end
        tick();
        expCntB++;
        checks++; if (cntB !== 16'(expCntB) || busB.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL small_cnt: cnt %0d valid %b want %0d 0", cntB, busB.out_valid, expCntB); end
        for (int k = 0; k < 8; k++) begin bytes[k] = 8'($urandom()); invs[k] = 1'($urandom()); end
        for (int k = 0; k <= 8; k++) begin
            busB.in_valid = (k < 8);
            busB.in_data  = (k < 8) ? bytes[k] : 8'h00;
            busB.in_inv   = (k < 8) ? invs[k] : 1'b0;
            #1;
            if (k > 0) begin
                m = refWord({120'd0, bytes[k-1]}, invs[k-1], 1);
                checks++;
                if (busB.out_valid !== 1'b1 || busB.out_data !== m[7:0] || busB.out_inv !== invs[k-1]) begin
                    errors++; $display("[TB] FAIL small_stream[%0d]: got v%b i%b %h want v1 i%b %h", k-1, busB.out_valid, busB.out_inv, busB.out_data, invs[k-1], m[7:0]);
                end
            end
            tick();
        end
        busB.in_valid = 0;
    endtask

    task automatic test_corner_wide();
        logic [127:0] d;
        logic [127:0] m;
        logic         inv;
        busC.out_ready = 1;
        for (int w = 0; w < 3; w++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            inv = 1'($urandom());
            m = refWord(d, inv, 16);
            busC.in_valid = 1; busC.in_data = d; busC.in_inv = inv;
            tick();
            busC.in_valid = 0;
            for (int j = 0; j < 3; j++) begin
                #1;
                checks++; if (busC.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL wide_early[%0d.%0d]: out_valid %b want 0", w, j, busC.out_valid); end
                tick();
            end
            #1;
            checks++;
            if (busC.out_valid !== 1'b1 || busC.out_data !== m || busC.out_inv !== inv) begin
                errors++; $display("[TB] FAIL wide_data[%0d]: got v%b i%b %h want v1 i%b %h", w, busC.out_valid, busC.out_inv, busC.out_data, inv, m);
            end
            tick();
            expCntC++;
            checks++; if (cntC !== 16'(expCntC)) begin errors++; $display("[TB] FAIL wide_cnt[%0d]: got %0d want %0d", w, cntC, expCntC); end
        end
    endtask

    task automatic checkOutput();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    initial begin
        rst = 1;
        applyStimulus();
        for (int i = 0; i < 256; i++) refFwd[i] = affineSbox(8'(i));
        for (int i = 0; i < 256; i++) refInv[refFwd[i]] = 8'(i);
        test_reset();
        test_forward();
        test_inverse();
        test_back_to_back();
        test_reset_midstream();
        test_counter_wrap();
        test_corner_small();
        test_corner_wide();
        checkOutput();
        $finish;
    end

endmodule

// File: doc/sbox_pipe.md
# sbox_pipe

Pipelined, multi-lane AES byte-substitution unit. Each accepted word of LANES bytes passes through the forward S-box (encrypt) or the inverse S-box (decrypt), selected per transaction. Results emerge after a fixed STAGES-cycle latency behind a valid/ready handshake with full back-pressure. It replaces the single-byte combinational S-box in the SubBytes/InvSubBytes and key-expansion datapaths.

## Interface
- LANES, default 4: number of bytes substituted in parallel (1..16).
- STAGES, default 2: pipeline depth in cycles (1..4). Table lookup is in stage 1; later stages are pure register slices.
- CNT_W, default 16: width of the transaction counter.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input word present.
- in_ready  out  1  unit can accept a word this cycle.
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled with in_data.
- in_data  in  8*LANES  input bytes; lane i = bits [8i+7:8i].
- out_valid  out  1  result word present.
- out_ready  in  1  downstream accepts the result.
- out_inv  out  1  mode bit that travelled with out_data.
- out_data  out  8*LANES  substituted bytes, lane order preserved.
- xfer_cnt  out  CNT_W  count of completed output transfers.

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Each stage holds {valid, inv, data}. Global advance enable is en = !out_valid | out_ready. in_ready = en, which is combinational from out_ready and the last-stage valid.
- When en is 1, every stage loads from its predecessor. Stage 1 loads valid = in_valid and the substituted in_data: lane i = in_inv ? INV_SBOX[byte] : FWD_SBOX[byte]. Inv bit is forwarded unchanged.
- When en is 0, all stages hold. Data and mode stay stable on the outputs while out_valid=1 and out_ready=0.
- Bubbles are not collapsed: an empty stage advances in lockstep with full ones.
- Lanes are independent. Mode applies to all lanes of a word. Mixed-mode words in flight are legal, and each keeps its own mode.
- xfer_cnt increments by 1 on each output transfer and wraps from 2^CNT_W-1 to 0.
- Data and inv registers need no reset. Only the valid bits and xfer_cnt are reset.

## Timing
- Reset values: all stage valids 0, out_valid 0, xfer_cnt 0. in_ready reads 1 during and after reset, because out_valid is 0. out_data and out_inv are don't-care while out_valid=0.
- rst asserted mid-operation discards every in-flight word on that edge. No output transfer completes in the reset cycle. An input presented during rst is dropped.
- Latency: a word accepted at edge N is presented with out_valid=1 after edge N+STAGES-1, i.e. it is visible in cycle N+STAGES-1 relative to the accept cycle, assuming no stall. Each stalled cycle adds one.
- Throughput: one word per cycle while out_ready=1.
- With the pipeline full and out_ready=0, in_ready=0. When out_ready rises, accept and emit happen in the same cycle.
- Simultaneous output transfer and counter wrap: the count goes to 0 and no flag is raised.

## Structure
- Shared package aes_pkg holds:
  - the 256-entry FWD_SBOX and INV_SBOX constant tables;
  - the functions sbox_fwd(byte) and sbox_inv(byte);
  - the byte typedef.
  The existing key-expansion block moves to these package functions.
- One sub-module, sbox_lane: combinational 8-bit lookup with an inv select, instantiated LANES times in stage 1. All pipeline registers, handshake and counter logic live in sbox_pipe.

## Test plan
- Forward lookups, LANES=4, STAGES=2, out_ready=1. in_data=0xff_53_01_00 with inv=0 -> out_data=0x16_ed_7c_63 two cycles later; xfer_cnt=1.
- Inverse lookups. in_data=0x16_ed_7c_63 with inv=1 -> 0xff_53_01_00. Sweep all 256 bytes in both modes, checking fwd then inv round-trip is the identity.
- Back-pressure. Stream 6 words with alternating inv while out_ready toggles 1,0,0,1,… Verify:
  - output order and mode are preserved;
  - out_data is stable during stalls;
  - in_ready=0 only while full and out_ready=0;
  - there is no loss or duplication.
- Reset mid-stream. Fill 2 words, assert rst for 1 cycle -> out_valid=0 and xfer_cnt=0 next cycle; no stale word appears afterwards.
- Counter wrap, CNT_W=4. Perform 17 output transfers -> xfer_cnt reads 15 then 0 then 1.
- Parameter corners. LANES=1, STAGES=1: 0x53 inv=0 -> 0xed one cycle after accept. LANES=16, STAGES=4: latency is 4 cycles.
